btn_conditioner: RTL
====================

# btn_conditioner

Input-conditioning stage between a raw push-button pin and the modboard CPLD's LED counter logic. Synchronises the asynchronous button level into the `pG0` domain and debounces it with a four-state FSM. Emits single-cycle press, release and long-press strobes plus a debounced level. Keeps a 4-bit press count that downstream logic drives onto the `p3A*` LEDs or uses as a counter enable.

## Interface
- `DEBOUNCE`, 1000, consecutive stable cycles needed to accept a level change; legal range 2 .. 2^`CNT_W`-1.
- `LONG`, 12000, cycles held (measured from the press strobe) before `long_press` fires; legal range `DEBOUNCE`+1 .. 2^`CNT_W`-1.
- `CNT_W`, 14, width of the debounce and hold counters.
- `ACTIVE_LOW`, 0, 1 = pin reads 0 when pressed; inverted before synchronisation.
- `pG0`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `p3B2`  in  1  raw button pin; asynchronous, may bounce.
- `btn_level`  out  1  debounced level; 1 = pressed.
- `press`  out  1  one-cycle strobe on accepted press.
- `release`  out  1  one-cycle strobe on accepted release.
- `long_press`  out  1  one-cycle strobe, at most once per press.
- `press_count`  out  4  number of accepted presses, mod 16.

## Operation
- Synchroniser: two flops `s1` → `s2` on `p3B2` (XOR `ACTIVE_LOW`). Reset loads both with 0, the logical released level.
- FSM states:
  - IDLE: `s2`=1 → PRESS_WAIT, debounce counter `dcnt` ← 0.
  - PRESS_WAIT:
    - `s2`=0 → IDLE.
    - `s2`=1 and `dcnt`==`DEBOUNCE`-1 → PRESSED, `press` ← 1, `press_count` += 1, hold counter `hcnt` ← 0.
    - Otherwise `dcnt` += 1.
  - PRESSED: `s2`=0 → RELEASE_WAIT, `dcnt` ← 0.
  - RELEASE_WAIT:
    - `s2`=1 → PRESSED; this is a bounce, with no strobe and `hcnt` kept.
    - `s2`=0 and `dcnt`==`DEBOUNCE`-1 → IDLE, `release` ← 1.
    - Otherwise `dcnt` += 1.
- `btn_level` = 1 exactly in PRESSED and RELEASE_WAIT; registered.
- Hold counter:
  - In PRESSED and RELEASE_WAIT, `hcnt` increments each cycle and saturates at `LONG`.
  - `long_press` is 1 for the single cycle after `hcnt` goes from `LONG`-1 to `LONG`.
  - Saturation guarantees one strobe per press, including bounces back into PRESSED.
- `press_count` wraps 15 → 0 with no flag.
- All outputs are registered; there is no combinational path from `p3B2` to any output.
- Simultaneous events:
  - `long_press` and `release` can assert in the same cycle; both are emitted.
  - `press` and `long_press` cannot coincide, because `LONG` > `DEBOUNCE`.

## Timing
- Reset values: state IDLE, `s1`=`s2`=0, `dcnt`=`hcnt`=0; all outputs 0, including `press_count`.
- Reset takes effect at the first `pG0` edge with `rst`=1. It overrides every transition and strobe in that cycle.
- Reset mid-press:
  - No `release` is emitted.
  - If the button is still held when reset deasserts, a new `press` follows after the normal latency.
- Press latency: logical `p3B2` goes high before edge 0 and stays high → `press` is high in the cycle after edge `DEBOUNCE`+2.
  - `btn_level` rises on the same edge.
  - Release latency is symmetric.
- Any single-cycle glitch of `s2` during PRESS_WAIT or RELEASE_WAIT restarts the wait from the stable state.
- `long_press` is high in the cycle after edge `DEBOUNCE`+2+`LONG`, measured from the same edge 0, if the button is held continuously.
- Every strobe is exactly one cycle wide.

## Test plan
All scenarios use `DEBOUNCE`=4, `LONG`=20, `ACTIVE_LOW`=0.
- Clean press and release: `p3B2` high before edge 0 and held for 30 cycles, then low → `press` high after edge 6; `btn_level` 1 from edge 6; `long_press` after edge 26; `release` and `btn_level`=0 six edges after the falling input; `press_count`=1.
- Bounce rejection on press: `p3B2` toggles 1,0,1,0 with 2-cycle periods, then 0 → no strobe; `btn_level` stays 0; FSM ends in IDLE.
- Release bounce: press accepted, then a 2-cycle low pulse, then high for 30 cycles → no `release`; exactly one `long_press`; `btn_level` stays 1 throughout.
- Wrap: 17 clean short presses (8 cycles high, 10 low) → `press_count` = 1; 17 `press` and 17 `release` strobes; no `long_press`.
- Reset mid-press: assert `rst` for 1 cycle while in PRESSED with `p3B2` still high → all outputs 0 after that edge; no `release`; new `press` 6 edges after `rst` falls; `press_count`=1.
- Active-low pin: `ACTIVE_LOW`=1, pin idles high, driven low for 10 cycles → `press` after edge 6; `release` 6 edges after the pin returns high.

Source files
------------

// File: rtl/btn_conditioner.sv
// Push-button conditioner: two-flop synchroniser, four-state debounce FSM,
// press/release/long-press strobes, debounced level and a 4-bit press count.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE   = 1000,
    parameter int unsigned LONG       = 12000,
    parameter int unsigned CNT_W      = 14,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic       pG0,
    input  logic       rst,
    input  logic       p3B2,
    output logic       btn_level,
    output logic       press,
    // "release" is a reserved word, hence the suffix
    output logic       release_stb,
    output logic       long_press,
    output logic [3:0] press_count
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] LONG_C    = CNT_W'(LONG);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_t           state;
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] hcnt;

    always_ff @(posedge pG0) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= p3B2 ^ ACTIVE_LOW;
            s2 <= s1;
        end
    end

    always_ff @(posedge pG0) begin
        if (rst) begin
            state       <= IDLE;
            dcnt        <= '0;
            hcnt        <= '0;
            btn_level   <= 1'b0;
            press       <= 1'b0;
            release_stb <= 1'b0;
            long_press  <= 1'b0;
            press_count <= '0;
        end else begin
            press       <= 1'b0;
            release_stb <= 1'b0;
            long_press  <= 1'b0;

            // Hold counter saturates at LONG, so a bounce back into PRESSED cannot re-fire
            if ((state == PRESSED || state == RELEASE_WAIT) && hcnt != LONG_C) begin
                hcnt <= hcnt + ONE;
                if (hcnt == LONG_LAST)
                    long_press <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (s2) begin
                        state <= PRESS_WAIT;
                        dcnt  <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s2) begin
                        state <= IDLE;
                    end else if (dcnt == DB_LAST) begin
                        state       <= PRESSED;
                        btn_level   <= 1'b1;
                        press       <= 1'b1;
                        press_count <= press_count + 4'd1;
                        hcnt        <= '0;
                    end else begin
                        dcnt <= dcnt + ONE;
                    end
                end
                PRESSED: begin
                    if (!s2) begin
                        state <= RELEASE_WAIT;
                        dcnt  <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (s2) begin
                        state <= PRESSED;
                    end else if (dcnt == DB_LAST) begin
                        state       <= IDLE;
                        btn_level   <= 1'b0;
                        release_stb <= 1'b1;
                    end else begin
                        dcnt <= dcnt + ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
